// File: rtl/ps2_host_transmitter.sv
// ps2_host_transmitter: sends one command byte from the core to a PS/2 device.
// The device clock is oversampled on Clock; both lines are driven through
// open-drain pull-low enables, and the top level turns these into tristates.
// Ports:
//   Clock, Reset            system clock (posedge) and async active-high reset
//   iPS2_Clock, iPS2_Data   raw PS/2 lines (clock is synchronized and filtered,
//                           data is synchronized only)
//   oPS2_Clock_Low/Data_Low 1 = pull the line low, 0 = release
//   iData, iData_Valid      byte and send request (taken only while oBusy=0)
//   oBusy                   transfer in progress
//   oDone, oError           one-cycle completion / abort pulses
//   oErrorCode              01 timeout, 10 no ACK; holds last value
// Optional build macro PS2_TX_RETRY_EN: retry a failed transfer twice
// before oError is reported.
module ps2_host_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_CYCLES  = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPS2_Clock,
  input  logic       iPS2_Data,
  output logic       oPS2_Clock_Low,
  output logic       oPS2_Data_Low,
  input  logic [7:0] iData,
  input  logic       iData_Valid,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError,
  output logic [1:0] oErrorCode
);

  localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW = $clog2(FILTER_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_ACK     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
`ifdef PS2_TX_RETRY_EN
  localparam logic [2:0] S_GAP     = 3'd5;
`endif

  logic [2:0]     state_q, state_d;
  logic           csync1_q, csync1_d, csync2_q, csync2_d;
  logic           dsync1_q, dsync1_d, dsync2_q, dsync2_d;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [ICW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [3:0]     bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic [8:0]     sh_q, sh_d;
  logic           clk_low_q, clk_low_d;
  logic           data_low_q, data_low_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
  logic [1:0]     err_code_q, err_code_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]     retry_q, retry_d;
`endif

  logic       fall;
  logic       ack_seen;
  logic       fail;
  logic [1:0] fail_code;

  always_comb begin
    csync1_d = iPS2_Clock;
    csync2_d = csync1_q;
    dsync1_d = iPS2_Data;
    dsync2_d = dsync1_q;

    // Filtered clock flips only after FILTER_CYCLES consecutive disagreeing samples.
    filt_d = filt_q;
    fcnt_d = '0;
    if (csync2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_CYCLES - 1)) filt_d = csync2_q;
      else                                   fcnt_d = fcnt_q + FCW'(1);
    end
    fall = filt_q & ~filt_d;

    state_d    = state_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_d      = tmo_q;
    bit_d      = bit_q;
    data_d     = data_q;
    sh_d       = sh_q;
    clk_low_d  = clk_low_q;
    data_low_d = data_low_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    err_code_d = err_code_q;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif
    ack_seen   = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (iData_Valid) begin
          data_d    = iData;
          busy_d    = 1'b1;
          clk_low_d = 1'b1;
          inh_cnt_d = ICW'(INHIBIT_CYCLES - 1);
          state_d   = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d   = 2'd0;
`endif
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          // Request-to-send: start bit on data, clock released, timeout armed.
          clk_low_d  = 1'b0;
          data_low_d = 1'b1;
          tmo_d      = TCW'(TIMEOUT_CYCLES - 1);
          bit_d      = 4'd0;
          sh_d       = {~^data_q, data_q};
          state_d    = S_SEND;
        end else begin
          inh_cnt_d = inh_cnt_q - ICW'(1);
        end
      end
      S_SEND: begin
        if (fall) begin
          if (bit_q != 4'd9) begin
            // Edges 1..9 put data LSB first, then parity, on the wire.
            data_low_d = ~sh_q[0];
            sh_d       = {1'b0, sh_q[8:1]};
            bit_d      = bit_q + 4'd1;
          end else begin
            data_low_d = 1'b0;
            state_d    = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_seen = 1'b1;
          if (!dsync2_q) begin
            state_d = S_WAIT;
          end else begin
            fail      = 1'b1;
            fail_code = 2'b10;
          end
        end
      end
      S_WAIT: begin
        if (dsync2_q && filt_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`ifdef PS2_TX_RETRY_EN
      S_GAP: begin
        if (inh_cnt_q == '0) begin
          clk_low_d = 1'b1;
          inh_cnt_d = ICW'(INHIBIT_CYCLES - 1);
          state_d   = S_INHIBIT;
        end else begin
          inh_cnt_d = inh_cnt_q - ICW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Timeout window spans SEND through WAIT; an ACK sample in the expiry cycle wins.
    if (state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT) begin
      if (tmo_q != '0) begin
        tmo_d = tmo_q - TCW'(1);
      end else if (!ack_seen && !done_d) begin
        fail      = 1'b1;
        fail_code = 2'b01;
      end
    end

    if (fail) begin
      clk_low_d  = 1'b0;
      data_low_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        inh_cnt_d = ICW'(INHIBIT_CYCLES - 1);
        state_d   = S_GAP;
      end else
`endif
      begin
        error_d    = 1'b1;
        err_code_d = fail_code;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      csync1_q   <= 1'b1;
      csync2_q   <= 1'b1;
      dsync1_q   <= 1'b1;
      dsync2_q   <= 1'b1;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      inh_cnt_q  <= '0;
      tmo_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      sh_q       <= '0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      csync1_q   <= csync1_d;
      csync2_q   <= csync2_d;
      dsync1_q   <= dsync1_d;
      dsync2_q   <= dsync2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_q      <= tmo_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      sh_q       <= sh_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign oPS2_Clock_Low = clk_low_q;
  assign oPS2_Data_Low  = data_low_q;
  assign oBusy          = busy_q;
  assign oDone          = done_q;
  assign oError         = error_q;
  assign oErrorCode     = err_code_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a behavioural PS/2 device clocks frames out
// of the DUT and the captured wire bits are compared with the expected frame.
module tb_ps2_host_transmitter;

  localparam int HALF = 180;  // device half-period; a whole frame plus ACK fits the timeout window

  logic       Clock = 1'b0;
  logic       Reset;
  logic       dev_clk;
  logic       dev_dat_low;
  logic [7:0] iData;
  logic       iData_Valid;
  logic       oPS2_Clock_Low, oPS2_Data_Low;
  logic       oBusy, oDone, oError;
  logic [1:0] oErrorCode;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = dev_clk & ~oPS2_Clock_Low;
  assign ps2_dat_line = ~(dev_dat_low | oPS2_Data_Low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(4000),
    .FILTER_CYCLES (4)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iPS2_Clock    (ps2_clk_line),
    .iPS2_Data     (ps2_dat_line),
    .oPS2_Clock_Low(oPS2_Clock_Low),
    .oPS2_Data_Low (oPS2_Data_Low),
    .iData         (iData),
    .iData_Valid   (iData_Valid),
    .oBusy         (oBusy),
    .oDone         (oDone),
    .oError        (oError),
    .oErrorCode    (oErrorCode)
  );

  always #5 Clock = ~Clock;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic       busy_at_done = 1'b1;
  logic [1:0] code_at_err = 2'b00;
  logic [1:0] lines_at_err = 2'b11;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle step; records every completion / error pulse seen on the way.
  task automatic tick();
    @(negedge Clock);
    if (oDone) begin
      done_cnt++;
      busy_at_done = oBusy;
    end
    if (oError) begin
      err_cnt++;
      code_at_err  = oErrorCode;
      lines_at_err = {oPS2_Clock_Low, oPS2_Data_Low};
    end
  endtask

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int  ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic start_req(input logic [7:0] d, output int inh_len, output logic busy1,
                           output logic ok);
    iData       = d;
    iData_Valid = 1'b1;
    inh_len     = 0;
    ok          = 1'b0;
    tick();
    iData_Valid = 1'b0;
    busy1       = oBusy;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (oPS2_Data_Low) ok = 1'b1;
      else begin
        if (oPS2_Clock_Low) inh_len++;
        tick();
      end
    end
  endtask

  task automatic dev_frame(input logic do_ack, input logic glitch, input logic inject,
                           input logic abort, output logic [10:0] bits);
    bits = '0;
    repeat (10) tick();
    bits[0] = ps2_dat_line;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      repeat (HALF / 2) tick();
      if (glitch) begin
        dev_clk = 1'b1; tick(); dev_clk = 1'b0;
      end
      if (inject && k == 3) begin
        iData = 8'h55; iData_Valid = 1'b1; tick(); iData_Valid = 1'b0;
      end
      if (abort && k == 5) begin
        Reset = 1'b1;
        #1;
        check("abort clk released", {31'd0, oPS2_Clock_Low}, 0);
        check("abort data released", {31'd0, oPS2_Data_Low}, 0);
        dev_clk = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        return;
      end
      repeat (HALF / 2) tick();
      dev_clk = 1'b1;
      if (k <= 10) bits[k] = ps2_dat_line;
      if (k == 10 && do_ack) dev_dat_low = 1'b1;
      if (k == 11) dev_dat_low = 1'b0;
      repeat (HALF / 2) tick();
      if (glitch) begin
        dev_clk = 1'b0; tick(); dev_clk = 1'b1;
      end
      repeat (HALF / 2) tick();
    end
  endtask

  task automatic run_ok(input logic [7:0] d, input logic glitch, input logic inject,
                        input string tag);
    int         d0, e0, inh_len;
    logic       busy1, ok;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_req(d, inh_len, busy1, ok);
    check({tag, " start bit"}, {31'd0, ok}, 1);
    check({tag, " busy after accept"}, {31'd0, busy1}, 1);
    check({tag, " inhibit length"}, inh_len, 20);
    dev_frame(1'b1, glitch, inject, 1'b0, bits);
    check({tag, " frame"}, {21'd0, bits}, {21'd0, frame_of(d)});
    check({tag, " done pulses"}, done_cnt - d0, 1);
    check({tag, " busy with done"}, {31'd0, busy_at_done}, 0);
    check({tag, " no error"}, err_cnt - e0, 0);
    repeat (40) tick();
    check({tag, " idle after"}, {30'd0, oBusy, oPS2_Data_Low}, 0);
    check({tag, " no extra done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int          d0, e0, inh_len, n;
    logic        busy1, ok;
    logic [10:0] bits;
    logic [7:0]  r;

    Reset = 1'b1; dev_clk = 1'b1; dev_dat_low = 1'b0; iData = '0; iData_Valid = 1'b0;
    repeat (3) tick();
    check("reset outputs", {26'd0, oPS2_Clock_Low, oPS2_Data_Low, oBusy, oDone, oError, 1'b0},
          0);
    check("reset code", {30'd0, oErrorCode}, 0);
    Reset = 1'b0;
    repeat (10) tick();

    run_ok(8'hED, 1'b0, 1'b0, "ed");
    run_ok(8'h07, 1'b0, 1'b0, "07");
    run_ok(8'h00, 1'b0, 1'b0, "00");
    run_ok(8'hFF, 1'b0, 1'b0, "ff");
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom);
      run_ok(r, 1'b0, 1'b0, "rand");
    end
    r = 8'($urandom);
    run_ok(r, 1'b1, 1'b0, "glitch");
    run_ok(8'hED, 1'b0, 1'b1, "ignore 55");

    // Device leaves data high at the ACK edge.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'h3C, inh_len, busy1, ok);
    check("noack start", {31'd0, ok}, 1);
    dev_frame(1'b0, 1'b0, 1'b0, 1'b0, bits);
    check("noack frame", {21'd0, bits}, {21'd0, frame_of(8'h3C)});
    check("noack error pulses", err_cnt - e0, 1);
    check("noack code", {30'd0, code_at_err}, 2);
    check("noack lines", {30'd0, lines_at_err}, 0);
    check("noack no done", done_cnt - d0, 0);
    check("noack busy", {31'd0, oBusy}, 0);

    // Device never clocks: timeout measured from the start bit.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'h81, inh_len, busy1, ok);
    check("tmo start", {31'd0, ok}, 1);
    n = 0;
    while (err_cnt == e0 && n < 4100) begin
      tick();
      n++;
    end
    check("tmo latency", n, 4000);
    check("tmo code", {30'd0, code_at_err}, 1);
    check("tmo lines", {30'd0, lines_at_err}, 0);
    check("tmo no done", done_cnt - d0, 0);
    repeat (20) tick();
    check("tmo code held", {30'd0, oErrorCode}, 1);
    check("tmo busy", {31'd0, oBusy}, 0);

    // Reset mid-frame.
    d0 = done_cnt; e0 = err_cnt;
    start_req(8'hED, inh_len, busy1, ok);
    check("abort start", {31'd0, ok}, 1);
    dev_frame(1'b1, 1'b0, 1'b0, 1'b1, bits);
    repeat (20) tick();
    check("abort no pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    check("abort idle", {30'd0, oBusy, oPS2_Clock_Low}, 0);
    check("abort code cleared", {30'd0, oErrorCode}, 0);
    r = 8'($urandom);
    run_ok(r, 1'b0, 1'b0, "after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
